// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR by a variable amount, at most STEP bits per clock.
// Start/done handshake; data_o holds the result from DONE until the next accepted request.
`timescale 1ns/1ps

module shift_unit_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ready_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11} mode_t;

    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    state_t           state;
    mode_t            mode;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   step;
    logic [WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] rot;

    // Status flags decode straight from the state register, so they never glitch on inputs.
    assign busy_o  = (state == SHIFT);
    assign done_o  = (state == DONE);
    assign ready_o = (state != SHIFT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        step    = (cnt < STEP_W) ? cnt : STEP_W;
        shifted = data_o;
        rot     = {data_o, data_o} >> step;
        case (mode)
            SLL: shifted = data_o << step;
            SRL: shifted = data_o >> step;
            SRA: shifted = WIDTH'($signed(data_o) >>> step);
            ROR: shifted = rot[WIDTH-1:0];
            default: shifted = data_o;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            data_o <= '0;
            cnt    <= '0;
            mode   <= SLL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        data_o <= data_i;
                        mode   <= mode_t'(mode_i);
                        cnt    <= shamt_i;
                        state  <= (shamt_i != '0) ? SHIFT : DONE;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    data_o <= shifted;
                    cnt    <= cnt - step;
                    if (cnt == step) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/shift_unit_iter.md
Name: shift_unit_iter

Overview:
Parametrised multi-cycle shifter, successor to the fixed shift-left-by-two block. It supports variable shift amount, four modes (SLL/SRL/SRA/ROR) and configurable width. It shifts at most STEP bits per clock, trading latency for area. Sits beside the ALU and is driven by a start/done handshake from the control FSM.

Parameters:
WIDTH, 32, datapath width in bits; power of two, >= 8
STEP, 4, maximum bits shifted per clock; 1..WIDTH-1
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  request; accepted only when ready_o=1
mode_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
shamt_i  input  SHW  shift amount 0..WIDTH-1
data_i  input  WIDTH  operand
data_o  output  WIDTH  working/result register
busy_o  output  1  high while state=SHIFT
done_o  output  1  one-cycle pulse, result valid
ready_o  output  1  high when state is IDLE or DONE

Behaviour:
- Reset (rst_i=1 at edge): state<=IDLE, data_o<=0, internal count<=0, latched mode<=0. busy_o=0, done_o=0, ready_o=1. Reset has priority over all other inputs.
- FSM states:
  - IDLE: ready_o=1.
  - SHIFT: busy_o=1, ready_o=0.
  - DONE: done_o=1, ready_o=1.
- Accept: at an edge where start_i=1 and state is IDLE or DONE:
  - data_o<=data_i, mode<=mode_i, cnt<=shamt_i.
  - Next state: SHIFT if shamt_i!=0, else DONE.
- SHIFT, each edge:
  - step=min(cnt,STEP).
  - data_o<=data_o shifted by step per latched mode; cnt<=cnt-step.
  - If cnt-step==0, next state DONE; else stay in SHIFT.
- Fill rules per step:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA replicates data_o[WIDTH-1].
  - ROR moves the low step bits to the MSBs.
  - Final result equals the single-shot shift/rotate of data_i by shamt_i.
- DONE lasts exactly one cycle unless a new start arrives:
  - start_i=1 in DONE: accepted (back-to-back, no bubble).
  - Otherwise next state IDLE.
- Latency: start sampled at edge k; done_o high in the cycle following edge k+ceil(shamt/STEP). For shamt=0, done_o is high in the cycle right after edge k.
- busy_o is high for exactly ceil(shamt/STEP) cycles.
- data_o shows partial results during SHIFT and is only meaningful when done_o=1. It holds the result in DONE and IDLE until the next accept.
- start_i while in SHIFT is ignored. No queuing; mode_i, shamt_i and data_i are don't-care then.
- shamt_i is never >= WIDTH by construction (SHW bits), so there is no overflow case.
- Reset mid-SHIFT aborts immediately: no done_o pulse, data_o=0.

Test Plan:
- WIDTH=32, STEP=4. SLL, data_i=4, shamt=2 -> 1 busy cycle, done_o pulse, data_o=0x00000010. Repeat with data_i=16, shamt=2 -> 0x00000040.
- SRA, data_i=0x80000000, shamt=31 -> busy_o high 8 cycles, data_o=0xFFFFFFFF at done. SRL, same data, shamt=31 -> 0x00000001.
- ROR, data_i=0x00000001, shamt=4 -> 0x10000000. ROR, data_i=0x12345678, shamt=8 -> 0x78123456.
- shamt=0, SLL, data_i=0xDEADBEEF -> done_o in next cycle, busy_o never high, data_o=0xDEADBEEF. Then start_i pulsed during a 20-bit SLL's SHIFT phase -> ignored; result 0xDEADBEEF<<20 = 0xEEF00000.
- Back-to-back: start_i held high in DONE -> new operation accepted the same cycle, ready_o never drops to an IDLE gap. Second op SRL 0xF0000000 by 28 -> 0x0000000F.
- Reset mid-SHIFT (3rd busy cycle of a shamt=31 op) -> next cycle busy_o=0, done_o=0, data_o=0, ready_o=1. Then STEP=1 build: SLL 1 by 5 -> 5 busy cycles, data_o=0x00000020.
